ctrl_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 16-bit datapath.
- Sits directly upstream of the datapath registers (PC, IR, MAR, MDR, ACC) and drives their load, increment and mux-select strobes.
- Runs a fetch/decode/execute FSM and a memory ready/timeout handshake.
- Decodes opcode from ir_q[15:12]; operand address is ir_q[11:0], routed by the datapath.

---
 rtl/ctrl_sequencer_if.sv | 66 ++++++
 rtl/ctrl_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer_if
// Desc     : Control bundle between the sequencer and the 16-bit datapath:
//            IR/flag/memory-ready inputs and the register/memory strobes.
// Revision : 1.0
// ============================================================================
interface ctrl_sequencer_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] ir_q;
    logic                 zero_flag;
    logic                 mem_ready;

    logic                 mar_sel;
    logic                 mar_load;
    logic                 ir_load;
    logic                 pc_inc;
    logic                 pc_load;
    logic                 mdr_load;
    logic                 acc_load;
    logic [2:0]           alu_op;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 halted;
    logic                 bus_error;

    // Sequencer side
    modport master (
        input  ir_q,
        input  zero_flag,
        input  mem_ready,
        output mar_sel,
        output mar_load,
        output ir_load,
        output pc_inc,
        output pc_load,
        output mdr_load,
        output acc_load,
        output alu_op,
        output mem_rd,
        output mem_wr,
        output halted,
        output bus_error
    );

    // Datapath / memory side
    modport slave (
        output ir_q,
        output zero_flag,
        output mem_ready,
        input  mar_sel,
        input  mar_load,
        input  ir_load,
        input  pc_inc,
        input  pc_load,
        input  mdr_load,
        input  acc_load,
        input  alu_op,
        input  mem_rd,
        input  mem_wr,
        input  halted,
        input  bus_error
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Desc     : Fetch/decode/execute control FSM for the 16-bit accumulator
//            datapath, with a memory ready handshake and timeout bus error.
// Revision : 1.0
// ============================================================================
module ctrl_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int MAX_WAIT  = 15,
    parameter int WAIT_W    = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ctrl_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        ST_FETCH_A = 3'd0,
        ST_FETCH_M = 3'd1,
        ST_DECODE  = 3'd2,
        ST_OPER_M  = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [3:0] c_op_nop = 4'h0;
    localparam logic [3:0] c_op_lda = 4'h1;
    localparam logic [3:0] c_op_sta = 4'h2;
    localparam logic [3:0] c_op_add = 4'h3;
    localparam logic [3:0] c_op_sub = 4'h4;
    localparam logic [3:0] c_op_and = 4'h5;
    localparam logic [3:0] c_op_jmp = 4'h6;
    localparam logic [3:0] c_op_jz  = 4'h7;
    localparam logic [3:0] c_op_hlt = 4'hF;

    localparam logic [2:0] c_alu_pass_b = 3'd0;
    localparam logic [2:0] c_alu_add    = 3'd1;
    localparam logic [2:0] c_alu_sub    = 3'd2;
    localparam logic [2:0] c_alu_and    = 3'd3;

    localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_bus_error;

    logic [3:0] w_opcode;
    logic       w_needs_operand;
    logic       w_timeout;

    // The operand field is routed to the MAR/PC by the datapath, not here.
    logic w_unused_operand;
    assign w_unused_operand = ^bus.ir_q[WORD_SIZE-5:0];

    assign w_opcode = bus.ir_q[WORD_SIZE-1 -: 4];

    always_comb begin
        w_needs_operand = 1'b0;
        case (w_opcode)
            c_op_lda, c_op_sta, c_op_add, c_op_sub, c_op_and:
                w_needs_operand = 1'b1;
            default:
                w_needs_operand = 1'b0;
        endcase
    end

    // Ready arriving in the same cycle the count hits the limit still wins.
    assign w_timeout = (r_wait_cnt == c_max_wait) && !bus.mem_ready;

    // ------------------------------------------------------------------
    // State, wait counter and sticky bus error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH_A;
            r_wait_cnt  <= '0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH_A: begin
                    r_state    <= ST_FETCH_M;
                    r_wait_cnt <= '0;
                end
                ST_FETCH_M: begin
                    if (bus.mem_ready) begin
                        r_state <= ST_DECODE;
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        r_state     <= ST_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_opcode == c_op_hlt) begin
                        r_state <= ST_HALT;
                    end else if (w_needs_operand) begin
                        r_state    <= ST_OPER_M;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state <= ST_FETCH_A;
                    end
                end
                ST_OPER_M: begin
                    if (bus.mem_ready) begin
                        r_state <= (w_opcode == c_op_sta) ? ST_FETCH_A : ST_EXEC;
                    end else if (w_timeout) begin
                        r_bus_error <= 1'b1;
                        r_state     <= ST_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_FETCH_A;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH_A;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobe decode; reset gates everything so nothing issues in that cycle
    // ------------------------------------------------------------------
    logic       w_mar_sel;
    logic       w_mar_load;
    logic       w_ir_load;
    logic       w_pc_inc;
    logic       w_pc_load;
    logic       w_mdr_load;
    logic       w_acc_load;
    logic [2:0] w_alu_op;
    logic       w_mem_rd;
    logic       w_mem_wr;
    logic       w_halted;

    always_comb begin
        w_mar_sel  = 1'b0;
        w_mar_load = 1'b0;
        w_ir_load  = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_load  = 1'b0;
        w_mdr_load = 1'b0;
        w_acc_load = 1'b0;
        w_alu_op   = c_alu_pass_b;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_halted   = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH_A: begin
                    w_mar_load = 1'b1;
                end
                ST_FETCH_M: begin
                    w_mem_rd  = 1'b1;
                    w_ir_load = bus.mem_ready;
                    w_pc_inc  = bus.mem_ready;
                end
                ST_DECODE: begin
                    case (w_opcode)
                        c_op_jmp: w_pc_load = 1'b1;
                        c_op_jz:  w_pc_load = bus.zero_flag;
                        default: begin
                            w_mar_sel  = w_needs_operand;
                            w_mar_load = w_needs_operand;
                        end
                    endcase
                end
                ST_OPER_M: begin
                    if (w_opcode == c_op_sta) begin
                        w_mem_wr = 1'b1;
                    end else begin
                        w_mem_rd   = 1'b1;
                        w_mdr_load = bus.mem_ready;
                    end
                end
                ST_EXEC: begin
                    w_acc_load = 1'b1;
                    case (w_opcode)
                        c_op_add: w_alu_op = c_alu_add;
                        c_op_sub: w_alu_op = c_alu_sub;
                        c_op_and: w_alu_op = c_alu_and;
                        default:  w_alu_op = c_alu_pass_b;
                    endcase
                end
                ST_HALT: begin
                    w_halted = 1'b1;
                end
                default: begin
                    w_halted = 1'b0;
                end
            endcase
        end
    end

    assign bus.mar_sel   = w_mar_sel;
    assign bus.mar_load  = w_mar_load;
    assign bus.ir_load   = w_ir_load;
    assign bus.pc_inc    = w_pc_inc;
    assign bus.pc_load   = w_pc_load;
    assign bus.mdr_load  = w_mdr_load;
    assign bus.acc_load  = w_acc_load;
    assign bus.alu_op    = w_alu_op;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.halted    = w_halted;
    assign bus.bus_error = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_sequencer
// Desc     : Scoreboard bench: per-cycle expected strobe vectors are queued as
//            stimulus is driven and compared on the following falling edge.
// Revision : 1.0
// ============================================================================
module tb_ctrl_sequencer;

    localparam int WORD_SIZE = 16;
    localparam int MAX_WAIT  = 15;
    localparam int WAIT_W    = 8;

    // Bit layout of the observed/expected strobe vector
    localparam logic [13:0] M_SEL   = 14'h2000;
    localparam logic [13:0] M_MARLD = 14'h1000;
    localparam logic [13:0] M_IRLD  = 14'h0800;
    localparam logic [13:0] M_PCINC = 14'h0400;
    localparam logic [13:0] M_PCLD  = 14'h0200;
    localparam logic [13:0] M_MDRLD = 14'h0100;
    localparam logic [13:0] M_ACCLD = 14'h0080;
    localparam logic [13:0] M_RD    = 14'h0008;
    localparam logic [13:0] M_WR    = 14'h0004;
    localparam logic [13:0] M_HALT  = 14'h0002;
    localparam logic [13:0] M_BERR  = 14'h0001;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ctrl_sequencer_if #(.WORD_SIZE(WORD_SIZE)) bus ();

    ctrl_sequencer #(
        .WORD_SIZE (WORD_SIZE),
        .MAX_WAIT  (MAX_WAIT),
        .WAIT_W    (WAIT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [13:0] alu(input logic [2:0] op);
        return {7'd0, op, 4'd0};
    endfunction

    logic [13:0] obs_vec;
    assign obs_vec = {bus.mar_sel, bus.mar_load, bus.ir_load, bus.pc_inc, bus.pc_load,
                      bus.mdr_load, bus.acc_load, bus.alu_op, bus.mem_rd, bus.mem_wr,
                      bus.halted, bus.bus_error};

    // Monitor: outputs have settled by the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {2'b00, obs_vec}, {2'b00, e});
            check("rd_wr_exclusive", 16'(bus.mem_rd & bus.mem_wr), 16'h0);
            check("inc_load_exclusive", 16'(bus.pc_inc & bus.pc_load), 16'h0);
        end
    end

    // One clock of stimulus plus the strobe vector expected during that clock
    task automatic step(input logic rst, input logic rdy, input logic [15:0] ir,
                        input logic zf, input logic [13:0] e, input string t);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.mem_ready = rdy;
        bus.ir_q      = ir;
        bus.zero_flag = zf;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Full instruction from FETCH_A back to the next FETCH_A boundary
    task automatic run_instr(input logic [15:0] ir, input logic zf,
                             input int wf, input int wo, input string t);
        logic [3:0]  op;
        logic [13:0] e;
        logic [2:0]  aop;
        op = ir[15:12];
        step(1'b0, 1'($urandom_range(0, 1)), ir, zf, M_MARLD, {t, "_fetch_a"});
        for (int i = 0; i < wf; i++)
            step(1'b0, 1'b0, ir, zf, M_RD, {t, "_fetch_wait"});
        step(1'b0, 1'b1, ir, zf, M_RD | M_IRLD | M_PCINC, {t, "_fetch_m"});
        case (op)
            4'h6:                    e = M_PCLD;
            4'h7:                    e = zf ? M_PCLD : 14'h0;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: e = M_SEL | M_MARLD;
            default:                 e = 14'h0;
        endcase
        step(1'b0, 1'($urandom_range(0, 1)), ir, zf, e, {t, "_decode"});
        if (op == 4'h2) begin
            for (int i = 0; i < wo; i++)
                step(1'b0, 1'b0, ir, zf, M_WR, {t, "_sta_wait"});
            step(1'b0, 1'b1, ir, zf, M_WR, {t, "_sta_done"});
        end else if (op >= 4'h1 && op <= 4'h5) begin
            for (int i = 0; i < wo; i++)
                step(1'b0, 1'b0, ir, zf, M_RD, {t, "_oper_wait"});
            step(1'b0, 1'b1, ir, zf, M_RD | M_MDRLD, {t, "_oper_m"});
            aop = (op == 4'h1) ? 3'd0 : 3'(op - 4'h2);
            step(1'b0, 1'($urandom_range(0, 1)), ir, zf, M_ACCLD | alu(aop), {t, "_exec"});
        end
    endtask

    initial begin
        bus.ir_q      = 16'h0000;
        bus.zero_flag = 1'b0;
        bus.mem_ready = 1'b1;

        step(1'b1, 1'b1, 16'h0000, 1'b0, 14'h0, "reset_0");
        step(1'b1, 1'b1, 16'h0000, 1'b0, 14'h0, "reset_1");

        for (int i = 0; i < 3; i++)
            run_instr(16'h0000, 1'($urandom_range(0, 1)), 0, 0, "nop");
        run_instr(16'h1025, 1'b0, 0, 0, "lda");
        run_instr(16'h7040, 1'b1, 0, 0, "jz_taken");
        run_instr(16'h7040, 1'b0, 0, 0, "jz_not");
        run_instr(16'h6123, 1'b0, 0, 0, "jmp");
        run_instr(16'h2010, 1'b0, 0, 3, "sta_w3");
        run_instr(16'h3011, 1'b1, 1, 0, "add");
        run_instr(16'h4012, 1'b0, 0, 2, "sub");
        run_instr(16'h5013, 1'b0, 2, 1, "and");
        run_instr(16'h9ABC, 1'b1, 0, 0, "illegal");
        // Ready arriving exactly at the wait limit completes normally
        run_instr(16'h0000, 1'b0, MAX_WAIT, 0, "fetch_edge");
        run_instr(16'h3020, 1'b0, 0, MAX_WAIT, "oper_edge");

        // Fetch timeout: no ready at the limit raises bus_error and halts
        step(1'b0, 1'b0, 16'h0000, 1'b0, M_MARLD, "to_fetch_a");
        for (int i = 0; i < MAX_WAIT; i++)
            step(1'b0, 1'b0, 16'h0000, 1'b0, M_RD, "to_wait");
        step(1'b0, 1'b0, 16'h0000, 1'b0, M_RD, "to_last");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 16'h0000, 1'b0, M_HALT | M_BERR, "to_halt");
        step(1'b1, 1'b1, 16'h0000, 1'b0, M_BERR, "to_reset");
        run_instr(16'h0000, 1'b0, 0, 0, "after_to");

        // HLT then 20 idle cycles
        run_instr(16'hF000, 1'b0, 0, 0, "hlt");
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 16'hF000, 1'b0, M_HALT, "halt_idle");
        step(1'b1, 1'b1, 16'hF000, 1'b0, 14'h0, "halt_reset");

        // Reset in the middle of an ADD operand read
        step(1'b0, 1'b1, 16'h3055, 1'b0, M_MARLD, "mid_fetch_a");
        step(1'b0, 1'b1, 16'h3055, 1'b0, M_RD | M_IRLD | M_PCINC, "mid_fetch_m");
        step(1'b0, 1'b0, 16'h3055, 1'b0, M_SEL | M_MARLD, "mid_decode");
        step(1'b0, 1'b0, 16'h3055, 1'b0, M_RD, "mid_oper");
        step(1'b1, 1'b0, 16'h3055, 1'b0, 14'h0, "mid_reset");
        run_instr(16'h1077, 1'b0, 0, 0, "after_mid");

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
